// File: rtl/commit_regfile_pkg.sv
// Shared types and constants for the commit stage: instruction types,
// register-file geometry and the store sequencer state encoding.
package commit_regfile_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef enum logic [3:0] {
    ITYPE_ALU    = 4'd0,
    ITYPE_LOAD   = 4'd1,
    ITYPE_STORE  = 4'd2,
    ITYPE_BRANCH = 4'd3,
    ITYPE_JAL    = 4'd4,
    ITYPE_JALR   = 4'd5,
    ITYPE_LUI    = 4'd6,
    ITYPE_AUIPC  = 4'd7
  } itype_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } store_state_e;

  // A retiring instruction updates architectural state unless it is a
  // branch or targets x0.
  function automatic logic commit_writes_rf(input logic [3:0]           itype,
                                            input logic [REG_IDX_W-1:0] rd);
    return (itype != ITYPE_BRANCH) && (rd != '0);
  endfunction

endpackage

// File: rtl/commit_regfile_reg_status_table.sv
// Register status table: one busy bit and producing ROB tag per
// architectural register, with two combinational decode read ports.
module commit_regfile_reg_status_table
  import commit_regfile_pkg::*;
#(
  parameter int TAG_W = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 commit_valid_in,
  input  logic [REG_IDX_W-1:0] commit_rd_in,
  input  logic [TAG_W-1:0]     commit_tag_in,
  input  logic                 issue_valid_in,
  input  logic [REG_IDX_W-1:0] issue_rd_in,
  input  logic [TAG_W-1:0]     issue_tag_in,
  input  logic [REG_IDX_W-1:0] rs1_in,
  input  logic [REG_IDX_W-1:0] rs2_in,
  output logic                 rs1_busy_out,
  output logic [TAG_W-1:0]     rs1_tag_out,
  output logic                 rs2_busy_out,
  output logic [TAG_W-1:0]     rs2_tag_out
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]    tag_q [NUM_REGS];
  logic [TAG_W-1:0]    tag_d [NUM_REGS];

  // Commit clears only when the retiring tag is still the registered
  // producer; an issue to the same register is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_valid_in && busy_q[commit_rd_in] &&
        (tag_q[commit_rd_in] == commit_tag_in)) begin
      busy_d[commit_rd_in] = 1'b0;
    end
    if (issue_valid_in && (issue_rd_in != '0)) begin
      busy_d[issue_rd_in] = 1'b1;
      tag_d[issue_rd_in]  = issue_tag_in;
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign rs1_busy_out = busy_q[rs1_in];
  assign rs1_tag_out  = tag_q[rs1_in];
  assign rs2_busy_out = busy_q[rs2_in];
  assign rs2_tag_out  = tag_q[rs2_in];

endmodule

// File: rtl/commit_regfile.sv
// Commit stage: retires ROB-head results into the architectural register
// file, sequences store writes to data memory and serves decode lookups.
module commit_regfile
  import commit_regfile_pkg::*;
#(
  parameter  int ROB_SIZE    = 8,
  parameter  int MEM_ADDR_W  = 16,
  parameter  int MEM_LATENCY = 2,
  localparam int TAG_W       = $clog2(ROB_SIZE)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  commit_in,
  input  logic                  store_valid_in,
  input  logic [TAG_W-1:0]      ix_in,
  input  logic [3:0]            iType_in,
  input  logic [XLEN-1:0]       value_in,
  input  logic [XLEN-1:0]       dest_in,
  output logic                  store_read_out,
  input  logic                  issue_valid_in,
  input  logic [REG_IDX_W-1:0]  issue_rd_in,
  input  logic [TAG_W-1:0]      issue_rob_ix_in,
  input  logic [REG_IDX_W-1:0]  rs1_in,
  input  logic [REG_IDX_W-1:0]  rs2_in,
  output logic [XLEN-1:0]       rs1_value_out,
  output logic [XLEN-1:0]       rs2_value_out,
  output logic                  rs1_busy_out,
  output logic                  rs2_busy_out,
  output logic [TAG_W-1:0]      rs1_tag_out,
  output logic [TAG_W-1:0]      rs2_tag_out,
  output logic                  mem_we_out,
  output logic [MEM_ADDR_W-1:0] mem_addr_out,
  output logic [XLEN-1:0]       mem_data_out,
  output store_state_e          store_state_out
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  logic [REG_IDX_W-1:0] commit_rd;
  logic                 commit_valid;

  assign commit_rd    = dest_in[REG_IDX_W-1:0];
  assign commit_valid = commit_in && commit_writes_rf(iType_in, commit_rd);

  // Byte-address bits outside the word address are not used by the store path.
  logic unused_dest;
  assign unused_dest = ^{dest_in[XLEN-1:MEM_ADDR_W+2], dest_in[1:0]};

  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [XLEN-1:0] rf_d [NUM_REGS];

  always_comb begin
    rf_d = rf_q;
    if (commit_valid) begin
      rf_d[commit_rd] = value_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  // No commit bypass: decode sees the pre-edge value while the ROB entry
  // still holds the result.
  assign rs1_value_out = (rs1_in == '0) ? '0 : rf_q[rs1_in];
  assign rs2_value_out = (rs2_in == '0) ? '0 : rf_q[rs2_in];

  commit_regfile_reg_status_table #(
    .TAG_W (TAG_W)
  ) u_status (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .commit_valid_in (commit_valid),
    .commit_rd_in    (commit_rd),
    .commit_tag_in   (ix_in),
    .issue_valid_in  (issue_valid_in),
    .issue_rd_in     (issue_rd_in),
    .issue_tag_in    (issue_rob_ix_in),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .rs1_busy_out    (rs1_busy_out),
    .rs1_tag_out     (rs1_tag_out),
    .rs2_busy_out    (rs2_busy_out),
    .rs2_tag_out     (rs2_tag_out)
  );

  // Store handshake: store_valid_in is a level-held request from the ROB
  // head, sampled only in IDLE; store_read_out is the single-cycle done
  // pulse that lets the ROB pop, so the same store is never accepted twice.
  store_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_we_q;
  logic             store_read_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]  mem_data_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mem_we_q     <= 1'b0;
      store_read_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      mem_we_q     <= 1'b0;
      store_read_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (store_valid_in) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= dest_in[MEM_ADDR_W+1:2];
            mem_data_q <= value_in;
            cnt_q      <= CNT_W'(MEM_LATENCY - 1);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            store_read_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_we_out      = mem_we_q;
  assign store_read_out  = store_read_q;
  assign mem_addr_out    = mem_addr_q;
  assign mem_data_out    = mem_data_q;
  assign store_state_out = state_q;

endmodule

// File: doc/commit_regfile.md
Name: commit_regfile

Overview:
- Commit stage directly downstream of the reorder buffer (ROB).
- Owns the 32x32 architectural register file and the register status table (busy bit plus ROB tag per register).
- Retires non-store instructions at the ROB head into the register file.
- Sequences store retirement to data memory through a small FSM, then returns a one-cycle store-done pulse to the ROB.
- Also serves decode operand lookups: value, busy and tag.

Parameters:
- ROB_SIZE, 8, ROB entries; TAG_W = $clog2(ROB_SIZE).
- MEM_ADDR_W, 16, data-memory word-address width.
- MEM_LATENCY, 2, cycles from mem_we_out to write-complete (BRAM pipeline).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- commit_in  in  1  ROB head is a ready non-store; retire this cycle
- store_valid_in  in  1  ROB head is a ready store
- ix_in  in  TAG_W  ROB index of head
- iType_in  in  4  head instruction type
- value_in  in  32  head result / store data
- dest_in  in  32  rd index (low 5 bits) or store byte address
- store_read_out  out  1  one-cycle pulse: store written, ROB may pop
- issue_valid_in  in  1  instruction with rd issued this cycle
- issue_rd_in  in  5  issued destination register
- issue_rob_ix_in  in  TAG_W  ROB tag allocated at issue
- rs1_in, rs2_in  in  5  decode source registers
- rs1_value_out, rs2_value_out  out  32  register file value (combinational)
- rs1_busy_out, rs2_busy_out  out  1  register awaiting ROB result
- rs1_tag_out, rs2_tag_out  out  TAG_W  ROB tag producing the register
- mem_we_out  out  1  data-memory write strobe
- mem_addr_out  out  MEM_ADDR_W  word address = dest_in[MEM_ADDR_W+1:2]
- mem_data_out  out  32  store data

Behaviour:
- Reset: all registers 0, all busy 0, all tags 0, FSM IDLE; mem_we_out, store_read_out, mem_addr_out, mem_data_out all 0. Reset mid-store aborts the store: FSM to IDLE, no pulse.
- Register x0: never written, never busy, always reads 0.
- Commit (registered, takes effect at the edge where commit_in=1):
  - Skip entirely if iType_in is BRANCH or rd=0.
  - Otherwise rf[rd] <= value_in.
  - If busy[rd] and tag[rd]==ix_in, clear busy[rd]. If the tag differs (a younger writer exists), leave busy and tag unchanged.
- Issue:
  - issue_valid_in with rd!=0 sets busy[rd]=1 and tag[rd]=issue_rob_ix_in at the edge.
  - Same cycle, same rd as a commit: issue wins (busy stays 1, new tag). The RF value is still written.
- Decode reads are combinational from current state, with no commit bypass. A register committing this cycle reads the old value with busy=1; the ROB entry still supplies the value.
- Store FSM:
  - IDLE: on store_valid_in, register mem_we_out=1 for exactly one cycle with mem_addr_out and mem_data_out captured. Load the counter with MEM_LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. At 0, go to RESP.
  - RESP: store_read_out=1 for one cycle, then go to IDLE.
  - store_valid_in is ignored outside IDLE, so the same store cannot retrigger. In IDLE, the cycle after RESP sees the new head.
  - Store-to-done latency is MEM_LATENCY+1 cycles after acceptance.
- commit_in and store_valid_in are mutually exclusive from the ROB. If both arrive, commit_in is processed and the store is accepted independently.
- mem_addr_out and mem_data_out hold their values outside the write cycle.

Decomposition:
- Shared package (types.svh): the iType enum (ALU, LOAD, STORE, BRANCH, ...) and constants NUM_REGS=32, REG_IDX_W=5.
- Sub-module reg_status_table: busy/tag array with issue-set / commit-clear priority logic and two read ports.
- Register file array and store FSM live in the top module.

Test Plan:
- Reset, then read rs1=5 -> value 0, busy 0, tag 0; mem_we_out=0, store_read_out=0.
- Issue rd=3 tag=2; next cycle rs1=3 -> busy 1, tag 2. Commit ix=2, dest=3, value=0xDEADBEEF -> next cycle value 0xDEADBEEF, busy 0.
- Issue rd=4 tag=1, then issue rd=4 tag=5, then commit ix=1 value=7 -> rf[4]=7, busy stays 1, tag 5.
- Commit dest=0 value=9 -> x0 still reads 0. Same-cycle issue rd=6 tag=3 and commit rd=6 ix=0 -> busy 1, tag 3.
- store_valid_in held with dest=0x40, value=0x55, MEM_LATENCY=2 -> mem_we_out high one cycle with addr=0x10, data=0x55; store_read_out pulses exactly once, 3 cycles after acceptance.
- rst_in asserted during WAIT -> store_read_out never pulses; FSM idle and accepts the next store.
